// File: rtl/uart_rpm_pkg.sv
// Shared states and command bytes for the UART RPM decoder.
// UART_RPM_CHECKSUM_EN adds the CSUM state.
package uart_rpm_pkg;

  localparam logic [7:0] CMD_SET      = 8'h91;
  localparam logic [7:0] CMD_STOP_ALL = 8'h90;
  localparam logic [7:0] CMD_RET      = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CHN,
    DATA,
`ifdef UART_RPM_CHECKSUM_EN
    CSUM,
`endif
    COMMIT
  } state_t;

endpackage

// File: rtl/uart_byte_timeout.sv
// Byte-gap watchdog: counts idle clocks while armed.
// expire is suppressed when a byte arrives in the same cycle.
module uart_byte_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic arm,
  input  logic kick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expire = arm && !kick &&
                  (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else if (!arm || kick)
      cnt <= '0;
    else if (!expire)
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_rpm_decoder.sv
// Decodes UART byte frames into per-channel motor targets.
// Define UART_RPM_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_rpm_decoder
  import uart_rpm_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CHN     = 4,
  parameter int STOP_THRESH = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rx_valid_i,
  input  logic [7:0]                    rx_data_i,
  output logic                          tr_valid_o,
  output logic [2:0]                    tr_chn_o,
  output logic [DATA_WIDTH-1:0]         tr_data_o,
  output logic [NUM_CHN*DATA_WIDTH-1:0] target_o,
  output logic [NUM_CHN-1:0]            stop_o,
  output logic                          err_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic signed [32:0] THR = 33'(STOP_THRESH);

  state_t state, nxt;

  logic [2:0]            chn_q;
  logic [2:0]            bcnt;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] tgt [NUM_CHN];

  logic chn_ld, dat_ld, stop_all, err_d, commit;
  logic arm, expire, last, stop_hit;
  logic signed [32:0] tval;

  assign commit = (state == COMMIT);
  assign last   = (bcnt == 3'(NB - 1));
  assign tval   = 33'($signed(asm_q));
  assign stop_hit = (tval > -THR) && (tval < THR);

`ifdef UART_RPM_CHECKSUM_EN
  logic [7:0] csum_q;
  assign arm = (state == DATA) || (state == CSUM);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      csum_q <= '0;
    else if (chn_ld)
      csum_q <= rx_data_i;
    else if (dat_ld)
      csum_q <= csum_q ^ rx_data_i;
  end
`else
  assign arm = (state == DATA);
`endif

  uart_byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .arm    (arm),
    .kick   (rx_valid_i),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt      = state;
    chn_ld   = 1'b0;
    dat_ld   = 1'b0;
    stop_all = 1'b0;
    err_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid_i) begin
          if (rx_data_i == CMD_SET)
            nxt = CHN;
          else if (rx_data_i == CMD_STOP_ALL)
            stop_all = 1'b1;
        end
      end
      // COMMIT treats a same-cycle byte as the first byte seen in CHN
      CHN, COMMIT: begin
        nxt = CHN;
        if (rx_valid_i) begin
          if (rx_data_i == CMD_RET) begin
            nxt = IDLE;
          end else if (rx_data_i == CMD_STOP_ALL) begin
            stop_all = 1'b1;
          end else if (rx_data_i < 8'(NUM_CHN)) begin
            chn_ld = 1'b1;
            nxt    = DATA;
          end else begin
            err_d = 1'b1;
            nxt   = IDLE;
          end
        end
      end
      DATA: begin
        if (rx_valid_i) begin
          dat_ld = 1'b1;
          if (last) begin
`ifdef UART_RPM_CHECKSUM_EN
            nxt = CSUM;
`else
            nxt = COMMIT;
`endif
          end
        end else if (expire) begin
          err_d = 1'b1;
          nxt   = IDLE;
        end
      end
`ifdef UART_RPM_CHECKSUM_EN
      CSUM: begin
        if (rx_valid_i) begin
          if (rx_data_i == csum_q) begin
            nxt = COMMIT;
          end else begin
            err_d = 1'b1;
            nxt   = CHN;
          end
        end else if (expire) begin
          err_d = 1'b1;
          nxt   = IDLE;
        end
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chn_ld_reset: begin end
      chn_q      <= '0;
      bcnt       <= '0;
      asm_q      <= '0;
      err_o      <= 1'b0;
      tr_valid_o <= 1'b0;
      tr_chn_o   <= '0;
      tr_data_o  <= '0;
      stop_o     <= '1;
      for (int i = 0; i < NUM_CHN; i++)
        tgt[i] <= '0;
    end else begin
      err_o      <= err_d;
      tr_valid_o <= commit;
      tr_chn_o   <= commit ? chn_q : '0;
      tr_data_o  <= commit ? asm_q : '0;
      if (chn_ld) begin
        chn_q <= rx_data_i[2:0];
        bcnt  <= '0;
        asm_q <= '0;
      end else if (dat_ld) begin
        asm_q <= DATA_WIDTH'({asm_q, rx_data_i});
        bcnt  <= bcnt + 3'd1;
      end
      for (int i = 0; i < NUM_CHN; i++) begin
        if (commit && chn_q == 3'(i)) begin
          tgt[i]    <= asm_q;
          stop_o[i] <= stop_hit;
        end
      end
      // a stop-all byte overrides a commit landing in the same cycle
      if (stop_all) begin
        stop_o <= '1;
        for (int i = 0; i < NUM_CHN; i++)
          tgt[i] <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHN; g++) begin : g_tgt
    assign target_o[g*DATA_WIDTH +: DATA_WIDTH] = tgt[g];
  end

endmodule

// File: tb/tb_uart_rpm_decoder.sv
// Scoreboard bench for uart_rpm_decoder (16-bit, 4 channels).
// Build with UART_RPM_CHECKSUM_EN to exercise the checksum frames.
module tb_uart_rpm_decoder;
  import uart_rpm_pkg::*;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          tr_valid_o;
  logic [2:0]    tr_chn_o;
  logic [DW-1:0] tr_data_o;
  logic [NC*DW-1:0] target_o;
  logic [NC-1:0] stop_o;
  logic          err_o;

  typedef struct {
    bit            is_err;
    logic [2:0]    chn;
    logic [DW-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  uart_rpm_decoder #(
    .DATA_WIDTH  (DW),
    .NUM_CHN     (NC),
    .STOP_THRESH (16),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .tr_valid_o (tr_valid_o),
    .tr_chn_o   (tr_chn_o),
    .tr_data_o  (tr_data_o),
    .target_o   (target_o),
    .stop_o     (stop_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
    end
  endtask

  task automatic csum(input logic [7:0] c);
`ifdef UART_RPM_CHECKSUM_EN
    send(c);
`else
    if (c == 8'h00) idle(0);
`endif
  endtask

  task automatic exp_commit(input logic [2:0] c,
                            input logic [DW-1:0] d);
    ev_t e;
    e.is_err = 1'b0;
    e.chn    = c;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    ev_t e;
    e.is_err = 1'b1;
    e.chn    = '0;
    e.data   = '0;
    exp_q.push_back(e);
  endtask

  function automatic logic [DW-1:0] tgt(input int i);
    return target_o[i*DW +: DW];
  endfunction

  // monitor: pops one expected event per observed pulse
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (tr_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL commit: unexpected chn=%0d data=%0h",
                   tr_chn_o, tr_data_o);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err || e.chn !== tr_chn_o ||
              e.data !== tr_data_o) begin
            errors++;
            $display("FAIL commit: got chn=%0d data=%0h exp err=%0b chn=%0d data=%0h",
                     tr_chn_o, tr_data_o, e.is_err, e.chn, e.data);
          end
        end
      end
      if (err_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL err: unexpected err pulse, expected none");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_err) begin
            errors++;
            $display("FAIL err: got err pulse expected commit chn=%0d data=%0h",
                     e.chn, e.data);
          end
        end
      end
      if (!tr_valid_o) begin
        if (tr_chn_o !== 3'd0 || tr_data_o !== '0) begin
          checks++;
          errors++;
          $display("FAIL tr_idle: chn=%0d data=%0h expected 0",
                   tr_chn_o, tr_data_o);
        end
      end
    end
  end

  initial begin
    rstn       = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    idle(3);
    chk("rst_stop", 64'(stop_o), 64'hF);
    chk("rst_target", 64'(target_o), 64'h0);
    chk("rst_tr_valid", 64'(tr_valid_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    rstn = 1'b1;
    idle(2);

    // 500 to channel 2
    exp_commit(3'd2, 16'd500);
    send(8'h91); send(8'h02); send(8'h01); send(8'hF4);
    csum(8'hF7);
    idle(4);
    chk("t1_stop", 64'(stop_o), 64'hB);
    chk("t1_tgt2", 64'(tgt(2)), 64'd500);

    // streamed update, FF arrives during COMMIT
    exp_commit(3'd2, 16'd10);
    send(8'h02); send(8'h00); send(8'h0A);
    csum(8'h08);
    send(8'hFF);
    idle(4);
    chk("t2_stop2", 64'(stop_o[2]), 64'h1);
    chk("t2_tgt2", 64'(tgt(2)), 64'd10);
    chk("t2_state", 64'(dut.state), 64'(IDLE));

    // bad channel
    exp_err();
    send(8'h91); send(8'h05);
    idle(4);
    chk("t3_state", 64'(dut.state), 64'(IDLE));

    // negative small target
    exp_commit(3'd1, 16'hFFFE);
    send(8'h91); send(8'h01); send(8'hFF); send(8'hFE);
    csum(8'h00);
    idle(4);
    chk("t3_tgt1", 64'(tgt(1)), 64'hFFFE);
    chk("t3_stop1", 64'(stop_o[1]), 64'h1);
    send(8'hFF);
    idle(2);

    // gap timeout mid-frame
    exp_err();
    send(8'h91); send(8'h00); send(8'h03);
    idle(TO);
    idle(3);
    chk("t4_tgt0", 64'(tgt(0)), 64'h0);
    chk("t4_state", 64'(dut.state), 64'(IDLE));

    // byte coincides with expiry
    exp_commit(3'd0, 16'h0304);
    send(8'h91); send(8'h00); send(8'h03);
    idle(TO - 1);
    send(8'h04);
    csum(8'h07);
    idle(4);
    chk("t4_tgt0_exp", 64'(tgt(0)), 64'h0304);
    chk("t4_stop0", 64'(stop_o[0]), 64'h0);
    send(8'hFF);
    idle(2);

    // stop-all
    send(8'h90);
    idle(3);
    chk("t5_stop", 64'(stop_o), 64'hF);
    chk("t5_target", 64'(target_o), 64'h0);

    // reset mid-frame
    exp_commit(3'd3, 16'h1234);
    send(8'h91); send(8'h03); send(8'h12); send(8'h34);
    csum(8'h25);
    idle(4);
    chk("t6_stop3", 64'(stop_o[3]), 64'h0);
    send(8'h03); send(8'h12);
    idle(1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_state", 64'(dut.state), 64'(IDLE));
    chk("t6_stop", 64'(stop_o), 64'hF);
    chk("t6_target", 64'(target_o), 64'h0);
    chk("t6_tr", 64'({tr_valid_o, tr_chn_o, tr_data_o}), 64'h0);
    chk("t6_err", 64'(err_o), 64'h0);
    idle(2);
    rstn = 1'b1;
    send(8'h34);
    idle(3);
    chk("t6_idle", 64'(dut.state), 64'(IDLE));

`ifdef UART_RPM_CHECKSUM_EN
    exp_commit(3'd3, 16'd100);
    send(8'h91); send(8'h03); send(8'h00); send(8'h64);
    send(8'h67);
    idle(4);
    chk("cs_tgt3", 64'(tgt(3)), 64'd100);
    send(8'hFF);
    exp_err();
    send(8'h91); send(8'h03); send(8'h00); send(8'h64);
    send(8'h66);
    idle(4);
    chk("cs_state", 64'(dut.state), 64'(CHN));
    chk("cs_tgt3_keep", 64'(tgt(3)), 64'd100);
`endif

    idle(5);
    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rpm_decoder.md
UART_RPM_DECODER -- requirements
Module: uart_rpm_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning target width in bits; legal values are multiples of 8 from 8 to 32.
REQ-002 SHALL have parameter NUM_CHN, default 4, meaning number of motor channels, 1..8.
REQ-003 SHALL have parameter STOP_THRESH, default 16, meaning magnitude below which a channel is stopped.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000000, meaning the maximum number of idle clocks allowed between bytes inside a frame.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_valid_i, input, 1, one-cycle strobe marking a received byte.
REQ-008 SHALL have port rx_data_i, input, 8, received byte.
REQ-009 SHALL have port tr_valid_o, output, 1, one-cycle commit pulse.
REQ-010 SHALL have port tr_chn_o, output, 3, channel of the commit.
REQ-011 SHALL have port tr_data_o, output, DATA_WIDTH, signed target of the commit.
REQ-012 SHALL have port target_o, output, NUM_CHN*DATA_WIDTH, last committed target per channel, with channel 0 in the LSBs.
REQ-013 SHALL have port stop_o, output, NUM_CHN, per-channel stop flags.
REQ-014 SHALL have port err_o, output, 1, one-cycle protocol-error pulse.

Function
REQ-015 SHALL implement the states IDLE, CHN, DATA, CSUM and COMMIT.
REQ-016 In IDLE: byte 0x91 SHALL go to CHN; byte 0x90 SHALL execute stop-all; any other byte SHALL be ignored.
REQ-017 In CHN: byte 0xFF SHALL go to IDLE; byte 0x90 SHALL execute stop-all and stay in CHN.
REQ-018 In CHN: any other byte with value below NUM_CHN SHALL latch it as the channel, clear the byte counter, and go to DATA.
REQ-019 In CHN: a byte with value of NUM_CHN or more SHALL pulse err_o and go to IDLE.
REQ-020 DATA SHALL accept DATA_WIDTH/8 bytes MSB first, shifting them into an assembly register; 0xFF and 0x90 are treated as plain data in this state.
REQ-021 After the last data byte, the FSM SHALL go to CSUM if checksum is enabled, otherwise to COMMIT.
REQ-022 COMMIT SHALL last one cycle, update the target and stop flag of the latched channel, and return to CHN so further channel updates can stream without a new header.
REQ-023 tr_valid_o, tr_chn_o and tr_data_o SHALL be registered and asserted in the cycle after COMMIT; tr_chn_o and tr_data_o SHALL be 0 whenever tr_valid_o is 0.
REQ-024 The stop rule SHALL set stop_o[ch] to 1 when the signed target is strictly greater than -STOP_THRESH and strictly less than +STOP_THRESH, and to 0 otherwise.
REQ-025 Stop-all SHALL set every stop_o bit to 1 and every target to 0 in the next cycle, and SHALL NOT pulse tr_valid_o.
REQ-026 In DATA and CSUM, TIMEOUT_CYC consecutive cycles without rx_valid_i SHALL pulse err_o, discard the partial frame, and go to IDLE.
REQ-027 If rx_valid_i coincides with timeout expiry, the byte SHALL be processed and the timeout SHALL NOT fire.
REQ-028 rx_valid_i arriving during COMMIT SHALL be processed as the first byte seen in CHN, with no byte lost.
REQ-029 Targets and stop flags of channels other than the addressed channel SHALL be unchanged by a commit.

Reset
REQ-030 On rstn low, the FSM SHALL go to IDLE immediately and asynchronously, including when reset is asserted mid-frame.
REQ-031 On reset, all targets, counters, tr_valid_o, tr_chn_o, tr_data_o and err_o SHALL be 0, and stop_o SHALL be all ones.

Configuration
REQ-032 Macro UART_RPM_CHECKSUM_EN, when defined, SHALL enable the CSUM state, which requires one extra byte equal to the XOR of the channel byte and all data bytes.
REQ-033 With UART_RPM_CHECKSUM_EN defined, a checksum mismatch SHALL pulse err_o, skip COMMIT, and return to CHN.
REQ-034 With UART_RPM_CHECKSUM_EN undefined, there SHALL be no CSUM state and no checksum logic; frames are header, then channel, then data only.

Structure
REQ-035 Package uart_rpm_pkg SHALL hold the state typedef and the command constants CMD_SET=0x91, CMD_STOP_ALL=0x90 and CMD_RET=0xFF.
REQ-036 The byte-gap timeout counter SHALL be a sub-module, uart_byte_timeout, with inputs clk, rstn, arm, kick and output expire.
REQ-037 The byte stream SHALL be supplied by the existing UART_recv, instantiated by the parent and not inside this block.

Verification
REQ-038 Defaults, checksum off: bytes 91 02 01 F4 SHALL produce a tr_valid_o pulse with chn=2 and data=500, stop_o=1011, and target_o[2]=500.
REQ-039 Continuing the previous test: bytes 02 00 0A FF SHALL produce a commit with data=10, stop_o[2]=1, and the FSM in IDLE.
REQ-040 Bytes 91 05 SHALL produce an err_o pulse, no commit, and the FSM in IDLE; bytes 91 01 FF FE SHALL produce target_o[1]=-2 and stop_o[1]=1.
REQ-041 Bytes 91 00 03 followed by TIMEOUT_CYC idle cycles SHALL produce one err_o pulse and no change to target_o[0]; a byte delivered exactly at expiry SHALL be accepted.
REQ-042 With UART_RPM_CHECKSUM_EN defined: bytes 91 03 00 64 67 SHALL commit 100 to channel 3, and bytes 91 03 00 64 66 SHALL produce err_o with no commit.
REQ-043 With several targets nonzero: byte 90 SHALL produce stop_o=1111 and all targets 0; rstn pulsed low between data bytes SHALL leave all outputs at their reset values.
